// File: rtl/count_ctrl.sv
// Prescaled terminal counter with run/pause/done control and one-shot or auto-reload modes.
// Optional down-counting via `COUNT_CTRL_DIR_EN (adds the dir input, latched on start).
module count_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_reload,
`ifdef COUNT_CTRL_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [DIV_W-1:0] presc_r, presc_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;
  logic [WIDTH-1:0] lim_r, lim_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic             reload_r, reload_s;
  logic             down_s;      // latched counting direction (1 = down)
  logic             cap_down_s;  // direction to be latched on a capture edge
  logic             term_s;
  logic [WIDTH-1:0] reload_val_s;

`ifdef COUNT_CTRL_DIR_EN
  logic dir_r, dir_s;
  assign down_s     = dir_r;
  assign cap_down_s = dir;
`else
  assign down_s     = 1'b0;
  assign cap_down_s = 1'b0;
`endif

  assign term_s       = down_s ? (count_r == CNT_ZERO) : (count_r == lim_r);
  assign reload_val_s = down_s ? lim_r : CNT_ZERO;

  // Next-state decode: stop dominates, then pause, then start.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    presc_s  = presc_r;
    done_s   = 1'b0;
    lim_s    = lim_r;
    div_s    = div_r;
    reload_s = reload_r;
`ifdef COUNT_CTRL_DIR_EN
    dir_s    = dir_r;
`endif
    if (stop) begin
      state_s = ST_IDLE;
      count_s = CNT_ZERO;
      presc_s = DIV_ZERO;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_s  = ST_RUN;
            count_s  = cap_down_s ? cfg_limit : CNT_ZERO;
            presc_s  = DIV_ZERO;
            lim_s    = cfg_limit;
            div_s    = cfg_div;
            reload_s = cfg_reload;
`ifdef COUNT_CTRL_DIR_EN
            dir_s    = dir;
`endif
          end else begin
            state_s = state_r;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_s = ST_PAUSE;
          end else if (presc_r == div_r) begin
            presc_s = DIV_ZERO;
            if (term_s) begin
              done_s = 1'b1;
              if (reload_r) begin
                count_s = reload_val_s;
              end else begin
                state_s = ST_DONE;
              end
            end else if (down_s) begin
              count_s = count_r - CNT_ONE;
            end else begin
              count_s = count_r + CNT_ONE;
            end
          end else begin
            presc_s = presc_r + DIV_ONE;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_PAUSE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          count_s = CNT_ZERO;
          presc_s = DIV_ZERO;
        end
      endcase
    end
    busy_s = (state_s == ST_RUN) || (state_s == ST_PAUSE);
  end

  // State, counter, prescaler, latched config and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      count_r  <= CNT_ZERO;
      presc_r  <= DIV_ZERO;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      lim_r    <= CNT_ZERO;
      div_r    <= DIV_ZERO;
      reload_r <= 1'b0;
`ifdef COUNT_CTRL_DIR_EN
      dir_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      presc_r  <= presc_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
      lim_r    <= lim_s;
      div_r    <= div_s;
      reload_r <= reload_s;
`ifdef COUNT_CTRL_DIR_EN
      dir_r    <= dir_s;
`endif
    end
  end

  assign count = count_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign state = state_r;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: driver pushes per-edge expectations, monitor pops after each edge.
module tb_count_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [7:0] cfg_limit = 8'd0;
  logic [3:0] cfg_div = 4'd0;
  logic       cfg_reload = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] count;
  logic       busy, done;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] st;
    logic [7:0] cnt;
    logic       dn;
    string      nm;
  } exp_t;

  exp_t sb[$];

  count_ctrl #(.WIDTH(8), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .cfg_limit(cfg_limit), .cfg_div(cfg_div), .cfg_reload(cfg_reload),
`ifdef COUNT_CTRL_DIR_EN
    .dir(dir),
`endif
    .count(count), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Monitor: one output snapshot per edge, compared against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    logic eb;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      eb = (e.st == S_RUN) || (e.st == S_PAUSE);
      n_checks++;
      if (state !== e.st || count !== e.cnt || busy !== eb || done !== e.dn) begin
        n_fail++;
        $display("FAIL %s: got state=%b count=%0d busy=%b done=%b, expected state=%b count=%0d busy=%b done=%b",
                 e.nm, state, count, busy, done, e.st, e.cnt, eb, e.dn);
      end
    end
  end

  task automatic step(input logic st, input logic sp, input logic ps,
                      input logic [1:0] es, input logic [7:0] ec, input logic ed, input string nm);
    exp_t e;
    @(negedge clk);
    start = st; stop = sp; pause = ps;
    e.st = es; e.cnt = ec; e.dn = ed; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic direct_check(input string nm, input logic [1:0] es, input logic [7:0] ec);
    n_checks++;
    if (state !== es || count !== ec || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got state=%b count=%0d busy=%b done=%b, expected state=%b count=%0d busy=0 done=0",
               nm, state, count, busy, done, es, ec);
    end
  endtask

  initial begin
    #1;
    direct_check("reset_state", S_IDLE, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, S_IDLE, 8'd0, 1'b0, "idle_after_reset");

    // One-shot L=3 D=0
    cfg_limit = 8'd3; cfg_div = 4'd0; cfg_reload = 1'b0;
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd0, 1'b0, "oneshot_c0");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd1, 1'b0, "oneshot_c1");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd2, 1'b0, "oneshot_c2");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd3, 1'b0, "oneshot_c3");
    step(1'b0, 1'b0, 1'b0, S_DONE, 8'd3, 1'b1, "oneshot_done");
    step(1'b0, 1'b0, 1'b0, S_DONE, 8'd3, 1'b0, "oneshot_hold1");
    step(1'b0, 1'b0, 1'b1, S_DONE, 8'd3, 1'b0, "done_pause_ignored");

    // Auto-reload L=2 D=2; mid-run config change and start in RUN are ignored
    cfg_limit = 8'd2; cfg_div = 4'd2; cfg_reload = 1'b1;
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd0, 1'b0, "reload_start");
    for (int k = 1; k <= 18; k++) begin
      if (k == 4) begin
        cfg_limit = 8'd1; cfg_div = 4'd0; cfg_reload = 1'b0;
      end
      step((k == 5) ? 1'b1 : 1'b0, 1'b0, 1'b0, S_RUN, 8'((k / 3) % 3),
           ((k % 3) == 0) && (((k / 3) % 3) == 0), $sformatf("reload_k%0d", k));
    end
    step(1'b0, 1'b1, 1'b0, S_IDLE, 8'd0, 1'b0, "reload_stop");

    // Pause L=5 D=0 at count 2, resume later: done 4 edges late
    cfg_limit = 8'd5; cfg_div = 4'd0; cfg_reload = 1'b0;
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd0, 1'b0, "pause_c0");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd1, 1'b0, "pause_c1");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd2, 1'b0, "pause_c2");
    step(1'b0, 1'b0, 1'b1, S_PAUSE, 8'd2, 1'b0, "pause_enter");
    step(1'b0, 1'b0, 1'b0, S_PAUSE, 8'd2, 1'b0, "pause_hold1");
    step(1'b0, 1'b0, 1'b1, S_PAUSE, 8'd2, 1'b0, "pause_hold2");
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd2, 1'b0, "pause_resume");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd3, 1'b0, "pause_c3");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd4, 1'b0, "pause_c4");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd5, 1'b0, "pause_c5");
    step(1'b0, 1'b0, 1'b0, S_DONE, 8'd5, 1'b1, "pause_done");
    step(1'b0, 1'b1, 1'b0, S_IDLE, 8'd0, 1'b0, "done_stop");

    // Terminal tick coinciding with pause
    cfg_limit = 8'd1; cfg_div = 4'd0; cfg_reload = 1'b0;
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd0, 1'b0, "tpause_c0");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd1, 1'b0, "tpause_c1");
    step(1'b0, 1'b0, 1'b1, S_PAUSE, 8'd1, 1'b0, "tpause_nodone");
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd1, 1'b0, "tpause_resume");
    step(1'b0, 1'b0, 1'b0, S_DONE, 8'd1, 1'b1, "tpause_done");

    // stop+pause+start together in RUN at count 4
    cfg_limit = 8'd9; cfg_div = 4'd0; cfg_reload = 1'b0;
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd0, 1'b0, "prio_c0");
    for (int k = 1; k <= 4; k++)
      step(1'b0, 1'b0, 1'b0, S_RUN, 8'(k), 1'b0, $sformatf("prio_c%0d", k));
    step(1'b1, 1'b1, 1'b1, S_IDLE, 8'd0, 1'b0, "prio_stop_wins");
    step(1'b0, 1'b0, 1'b1, S_IDLE, 8'd0, 1'b0, "idle_pause_ignored");

    // L=0 D=1 reload: terminal on every tick, count stays 0
    cfg_limit = 8'd0; cfg_div = 4'd1; cfg_reload = 1'b1;
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd0, 1'b0, "l0_start");
    for (int k = 1; k <= 4; k++)
      step(1'b0, 1'b0, 1'b0, S_RUN, 8'd0, (k % 2) == 0, $sformatf("l0_k%0d", k));
    step(1'b0, 1'b1, 1'b0, S_IDLE, 8'd0, 1'b0, "l0_stop");

`ifdef COUNT_CTRL_DIR_EN
    cfg_limit = 8'd3; cfg_div = 4'd0; cfg_reload = 1'b1; dir = 1'b1;
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd3, 1'b0, "down_c3");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd2, 1'b0, "down_c2");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd1, 1'b0, "down_c1");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd0, 1'b0, "down_c0");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd3, 1'b1, "down_reload");
    step(1'b0, 1'b0, 1'b0, S_RUN, 8'd2, 1'b0, "down_again");
    step(1'b0, 1'b1, 1'b0, S_IDLE, 8'd0, 1'b0, "down_stop");
    dir = 1'b0;
`endif

    // Async reset mid-RUN at count 7
    cfg_limit = 8'd20; cfg_div = 4'd0; cfg_reload = 1'b0;
    step(1'b1, 1'b0, 1'b0, S_RUN, 8'd0, 1'b0, "ares_c0");
    for (int k = 1; k <= 7; k++)
      step(1'b0, 1'b0, 1'b0, S_RUN, 8'(k), 1'b0, $sformatf("ares_c%0d", k));
    @(negedge clk);
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    rst_n = 1'b0;
    #1;
    direct_check("async_reset_midrun", S_IDLE, 8'd0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, S_IDLE, 8'd0, 1'b0, "post_reset_idle1");
    step(1'b0, 1'b0, 1'b0, S_IDLE, 8'd0, 1'b0, "post_reset_idle2");

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
